// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one partial product per clock, IDLE/CALC/DONE handshake.
// Define MULT_SIGNED_EN to add the Signed_Mode port and two's-complement support.
module shift_add_multiplier #(
   parameter int Operand_Width = 8,
   parameter int Product_Width = 2*Operand_Width
) (
   input  logic                     CLK,
   input  logic                     RST_n,
   input  logic [Operand_Width-1:0] Multiplicand,
   input  logic [Operand_Width-1:0] Multiplier,
   input  logic                     In_Valid,
   output logic                     In_Ready,
`ifdef MULT_SIGNED_EN
   input  logic                     Signed_Mode,
`endif
   output logic [Product_Width-1:0] Product,
   output logic                     Out_Valid,
   input  logic                     Out_Ready,
   output logic                     Busy
);

   localparam int AW = 2*Operand_Width;
   localparam int SW = $clog2(Operand_Width);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                   state;
   logic [Operand_Width-1:0] a_q, b_q;
   logic [Operand_Width-1:0] a_in, b_in;
   logic [AW-1:0]            acc, acc_next, partial;
   logic [SW-1:0]            step;
   logic                     last_step;
   logic [Product_Width-1:0] product_next;
`ifdef MULT_SIGNED_EN
   logic                     neg_q, neg_in, a_neg, b_neg;
`endif

   // Operands are latched as magnitudes; the sign is reapplied once the sum is complete.
   always_comb begin
`ifdef MULT_SIGNED_EN
      a_neg  = Signed_Mode & Multiplicand[Operand_Width-1];
      b_neg  = Signed_Mode & Multiplier[Operand_Width-1];
      a_in   = a_neg ? (~Multiplicand + 1'b1) : Multiplicand;
      b_in   = b_neg ? (~Multiplier + 1'b1) : Multiplier;
      neg_in = a_neg ^ b_neg;
`else
      a_in   = Multiplicand;
      b_in   = Multiplier;
`endif
   end

   always_comb begin
      partial   = b_q[step] ? (AW'(a_q) << step) : '0;
      acc_next  = acc + partial;
      last_step = (step == SW'(Operand_Width-1));
`ifdef MULT_SIGNED_EN
      product_next = Product_Width'(neg_q ? (~acc_next + 1'b1) : acc_next);
`else
      product_next = Product_Width'(acc_next);
`endif
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc     <= '0;
         step    <= '0;
         Product <= '0;
`ifdef MULT_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (In_Valid) begin
               a_q   <= a_in;
               b_q   <= b_in;
               acc   <= '0;
               step  <= '0;
`ifdef MULT_SIGNED_EN
               neg_q <= neg_in;
`endif
               state <= CALC;
            end
            CALC: begin
               acc <= acc_next;
               // Counter stops at the final step so it never wraps mid-operation.
               if (last_step) begin
                  Product <= product_next;
                  state   <= DONE;
               end else begin
                  step <= step + 1'b1;
               end
            end
            DONE: if (Out_Ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign In_Ready  = (state == IDLE);
   assign Busy      = (state == CALC);
   assign Out_Valid = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: vector table, hold/stall, mid-op reset, W=4 truncation, back-to-back.
module tb_shift_add_multiplier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  a8, b8;
   logic        iv8, ir8, ov8, or8, busy8;
   logic [15:0] p8;
   logic [3:0]  a4, b4;
   logic        iv4, ir4, ov4, or4, busy4;
   logic [5:0]  p4;
`ifdef MULT_SIGNED_EN
   logic        sm8;
   logic        sm4 = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift_add_multiplier dut8 (
      .CLK(clk), .RST_n(rst_n), .Multiplicand(a8), .Multiplier(b8),
      .In_Valid(iv8), .In_Ready(ir8),
`ifdef MULT_SIGNED_EN
      .Signed_Mode(sm8),
`endif
      .Product(p8), .Out_Valid(ov8), .Out_Ready(or8), .Busy(busy8));

   shift_add_multiplier #(.Operand_Width(4), .Product_Width(6)) dut4 (
      .CLK(clk), .RST_n(rst_n), .Multiplicand(a4), .Multiplier(b4),
      .In_Valid(iv4), .In_Ready(ir4),
`ifdef MULT_SIGNED_EN
      .Signed_Mode(sm4),
`endif
      .Product(p4), .Out_Valid(ov4), .Out_Ready(or4), .Busy(busy4));

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        sm;
      logic [15:0] exp;
      string       nm;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] sb[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   // Starts and ends on a falling edge; checks latency, Busy duration and result.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input logic [15:0] exp, input string nm);
      int guard = 0;
      int lat   = 0;
      int bsy   = 0;
      while (!ir8 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk({nm, " ready"}, {31'd0, ir8}, 32'd1);
      a8 = a; b8 = b; iv8 = 1'b1; or8 = 1'b0;
`ifdef MULT_SIGNED_EN
      sm8 = sm;
`else
      if (sm) $display("note: signed vector %s run unsigned", nm);
`endif
      @(negedge clk);
      iv8 = 1'b0;
      while (!ov8 && lat < 20) begin
         if (busy8) bsy++;
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, lat, 8);
      chk({nm, " busy"}, bsy, 8);
      chk({nm, " product"}, {16'd0, p8}, {16'd0, exp});
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
      chk({nm, " release"}, {31'd0, ov8}, 32'd0);
   endtask

   initial begin
      int lat, nacc, cyc, last;
      logic [7:0] ra, rb;

      vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01, "ffxff"});
      vecs.push_back('{8'h03, 8'h05, 1'b0, 16'h000F, "3x5"});
      vecs.push_back('{8'h12, 8'h34, 1'b0, 16'h03A8, "12x34"});
      vecs.push_back('{8'h01, 8'h01, 1'b0, 16'h0001, "1x1"});
      vecs.push_back('{8'h80, 8'h02, 1'b0, 16'h0100, "80x02"});
      vecs.push_back('{8'hFF, 8'h01, 1'b0, 16'h00FF, "ffx01"});
      vecs.push_back('{8'hA5, 8'h5A, 1'b0, 16'h3A02, "a5x5a"});
      vecs.push_back('{8'h00, 8'h00, 1'b0, 16'h0000, "0x0"});
`ifdef MULT_SIGNED_EN
      vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000, "s80x80"});
      vecs.push_back('{8'h80, 8'h01, 1'b1, 16'hFF80, "s80x01"});
      vecs.push_back('{8'hFD, 8'h07, 1'b1, 16'hFFEB, "sfdx07"});
      vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001, "sffxff"});
      vecs.push_back('{8'h07, 8'hFD, 1'b1, 16'hFFEB, "s07xfd"});
      sm8 = 1'b0;
`endif

      rst_n = 1'b0;
      a8 = '0; b8 = '0; iv8 = 1'b0; or8 = 1'b0;
      a4 = '0; b4 = '0; iv4 = 1'b0; or4 = 1'b0;
      #1;
      chk("rst in_ready", {31'd0, ir8}, 32'd1);
      chk("rst busy", {31'd0, busy8}, 32'd0);
      chk("rst out_valid", {31'd0, ov8}, 32'd0);
      chk("rst product", {16'd0, p8}, 32'd0);
      chk("rst w4 in_ready", {31'd0, ir4}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, vecs[i].nm);

      // Zero operand, consumer stalls five cycles while In_Valid pulses.
      a8 = 8'h00; b8 = 8'hA5; iv8 = 1'b1; or8 = 1'b0;
      @(negedge clk);
      iv8 = 1'b0;
      lat = 0;
      while (!ov8 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("hold latency", lat, 8);
      chk("hold product", {16'd0, p8}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         iv8 = k[0]; a8 = 8'hC3; b8 = 8'h7E;
         @(negedge clk);
         chk("hold out_valid", {31'd0, ov8}, 32'd1);
         chk("hold product", {16'd0, p8}, 32'd0);
         chk("hold in_ready", {31'd0, ir8}, 32'd0);
      end
      iv8 = 1'b0; or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
      chk("hold idle", {31'd0, ir8}, 32'd1);

      // Reset four steps into 0x12*0x34, then a clean operation.
      a8 = 8'h12; b8 = 8'h34; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid busy", {31'd0, busy8}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst in_ready", {31'd0, ir8}, 32'd1);
      chk("midrst busy", {31'd0, busy8}, 32'd0);
      chk("midrst out_valid", {31'd0, ov8}, 32'd0);
      chk("midrst product", {16'd0, p8}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(8'h03, 8'h05, 1'b0, 16'h000F, "post-rst");

      // Narrow instance: 4-bit operands, 6-bit truncated product.
      for (int v = 0; v < 2; v++) begin
         a4 = (v == 0) ? 4'hF : 4'hD;
         b4 = (v == 0) ? 4'hF : 4'hB;
         iv4 = 1'b1;
         @(negedge clk);
         iv4 = 1'b0;
         lat = 0;
         while (!ov4 && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         chk("w4 latency", lat, 4);
         chk("w4 product", {26'd0, p4}, (v == 0) ? 32'h21 : 32'h0F);
         or4 = 1'b1;
         @(negedge clk);
         or4 = 1'b0;
      end

      // Back-to-back with both handshakes held high.
      iv8 = 1'b1; or8 = 1'b1;
      nacc = 0; cyc = 0; last = -1;
      while ((nacc < 100 || sb.size() > 0) && cyc < 3000) begin
         if (ov8) begin
            if (sb.size() == 0) chk("b2b extra result", 32'd1, 32'd0);
            else chk("b2b product", {16'd0, p8}, {16'd0, sb.pop_front()});
         end
         if (ir8 && nacc < 100) begin
            ra = 8'($urandom); rb = 8'($urandom);
            a8 = ra; b8 = rb;
            sb.push_back(16'(int'(ra) * int'(rb)));
            if (last >= 0) chk("b2b interval", cyc - last, 10);
            last = cyc;
            nacc++;
         end else if (ir8) begin
            iv8 = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      iv8 = 1'b0; or8 = 1'b0;
      chk("b2b accepted", nacc, 100);
      chk("b2b drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter Operand_Width, default 8: width of both operands, legal range 2..32.
REQ-002 SHALL have parameter Product_Width, default 2*Operand_Width: result width, legal range Operand_Width..2*Operand_Width.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RST_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Multiplicand  input  Operand_Width  operand a, sampled on acceptance.
REQ-006 SHALL have port Multiplier  input  Operand_Width  operand b, sampled on acceptance.
REQ-007 SHALL have port In_Valid  input  1  operands present.
REQ-008 SHALL have port In_Ready  output  1  block can accept operands.
REQ-009 SHALL have port Signed_Mode  input  1  two's-complement operands when 1, sampled on acceptance; present only with MULT_SIGNED_EN.
REQ-010 SHALL have port Product  output  Product_Width  registered result, low Product_Width bits of a*b.
REQ-011 SHALL have port Out_Valid  output  1  Product holds a completed result.
REQ-012 SHALL have port Out_Ready  input  1  consumer takes result.
REQ-013 SHALL have port Busy  output  1  high while in CALC.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; In_Ready = (state==IDLE), Busy = (state==CALC), Out_Valid = (state==DONE).
REQ-015 IDLE: on edge with In_Valid=1, SHALL latch operands (and Signed_Mode), clear accumulator and step counter, go to CALC; In_Valid=0 stays IDLE.
REQ-016 CALC: each edge SHALL add (a AND b[step]) shifted left by step into the 2*Operand_Width accumulator and increment step; the edge performing step Operand_Width-1 SHALL load Product and go to DONE.
REQ-017 Latency SHALL be exactly Operand_Width edges from acceptance edge to Out_Valid=1, independent of operand values (zero operands included).
REQ-018 DONE: Product and Out_Valid SHALL hold stable until an edge with Out_Ready=1, then go to IDLE; no acceptance in the same edge (minimum initiation interval Operand_Width+2 cycles).
REQ-019 In_Valid asserted in CALC or DONE SHALL be ignored, with no change to latched operands.
REQ-020 Product SHALL change only on the edge entering DONE or on reset.
REQ-021 Unsigned result SHALL be exact modulo 2^Product_Width; Product_Width < 2*Operand_Width truncates upper bits.
REQ-022 Step counter SHALL be $clog2(Operand_Width) bits minimum and SHALL NOT wrap within an operation.

Reset
REQ-023 RST_n=0 SHALL immediately force state IDLE, In_Ready=1, Busy=0, Out_Valid=0, Product=0, accumulator, counter, latched operands=0.
REQ-024 Reset asserted mid-CALC or in DONE SHALL discard the operation; after release the first accepted operation SHALL complete with normal latency.

Configuration
REQ-025 Macro MULT_SIGNED_EN defined: Signed_Mode port exists; when latched 1, the block SHALL multiply operand magnitudes and negate the result on entry to DONE if operand signs differ; most-negative operands SHALL be handled exactly (magnitude 2^(Operand_Width-1)); latency unchanged.
REQ-026 MULT_SIGNED_EN undefined: Signed_Mode port, sign logic absent; all operands unsigned.

Verification
REQ-027 W=8, unsigned, a=0xFF, b=0xFF, In_Valid one cycle -> Out_Valid after exactly 8 edges, Product=0xFE01, Busy high for 8 cycles.
REQ-028 W=8, a=0, b=0xA5 -> Product=0x0000 after 8 edges; Out_Ready held 0 for 5 cycles -> Product, Out_Valid stable, In_Valid pulses ignored.
REQ-029 W=4, Product_Width=6, a=0xF, b=0xF -> Product=0x21 (225 mod 64 = 33).
REQ-030 MULT_SIGNED_EN, W=8, Signed_Mode=1: a=0x80, b=0x80 -> 0x4000; a=0x80, b=0x01 -> 0xFF80; a=0xFD (-3), b=0x07 -> 0xFFEB.
REQ-031 RST_n low at step 4 of a=0x12, b=0x34 -> outputs 0 immediately; after release a=0x03, b=0x05 -> Product=0x000F after 8 edges.
REQ-032 Back-to-back: 100 random pairs with In_Valid always 1, Out_Ready always 1 -> each result matches a*b, acceptance every 10 cycles (W=8).
